// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_extract.sv
// Byte/half lane select with sign/zero extension, plus the in-place lane mask
// used when merging a sub-word store into the existing RAM word.
module lsu_extract
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] value,
    output logic [31:0] lane_mask
);

    logic [4:0]  shamt;
    logic [31:0] shifted;

    assign shamt   = {addr_lo, 3'b000};
    assign shifted = word >> shamt;

    always_comb begin
        value     = word;
        lane_mask = 32'hFFFF_FFFF;
        case (funct3)
            F3_B: begin
                value     = {{24{shifted[7]}}, shifted[7:0]};
                lane_mask = 32'h0000_00FF << shamt;
            end
            F3_BU: begin
                value     = {24'h0, shifted[7:0]};
                lane_mask = 32'h0000_00FF << shamt;
            end
            F3_H: begin
                value     = {{16{shifted[15]}}, shifted[15:0]};
                lane_mask = 32'h0000_FFFF << shamt;
            end
            F3_HU: begin
                value     = {16'h0, shifted[15:0]};
                lane_mask = 32'h0000_FFFF << shamt;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Sub-word load/store front end for a word-addressed RAM with async read and
// negedge write. SB/SH are performed as read-modify-write through the WRITE state.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5
)
(
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Store,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ByteAddr,
    input  logic [31:0] WData,
    output logic        Ready,
    output logic        Done,
    output logic        Err,
    output logic [31:0] LoadData,
    output logic [31:0] MemAddr,
    output logic        MemWE,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    output logic [1:0]  fsm_state
);

    localparam logic [32:0] ADDR_LIMIT = 33'd4 << DEPTH_LOG2;

    lsu_state_e  state, next_state;
    logic        req_store;
    logic [2:0]  req_f3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        err_flag;
    logic [31:0] merge_word;
    logic [31:0] load_data;

    logic        misaligned, illegal, out_of_range, access_err;
    logic [31:0] ext_value, ext_mask, merge_next;
    logic        we_raw;

    lsu_extract u_extract (
        .word      (MemRData),
        .addr_lo   (req_addr[1:0]),
        .funct3    (req_f3),
        .value     (ext_value),
        .lane_mask (ext_mask)
    );

    assign misaligned = (((req_f3 == F3_H) || (req_f3 == F3_HU)) && req_addr[0])
                      || ((req_f3 == F3_W) && (req_addr[1:0] != 2'b00));
    assign illegal    = req_store ? !((req_f3 == F3_B) || (req_f3 == F3_H) || (req_f3 == F3_W))
                                  : ((req_f3 == 3'b011) || (req_f3[2:1] == 2'b11));
    assign out_of_range = ({1'b0, req_addr} >= ADDR_LIMIT);
    assign access_err   = misaligned || illegal || out_of_range;

    assign merge_next = (MemRData & ~ext_mask)
                      | ((req_wdata << {req_addr[1:0], 3'b000}) & ext_mask);

    // Handshake: Req is taken on any posedge where Ready=1 (IDLE only); every
    // accepted request yields exactly one Done pulse unless Reset aborts it.
    always_comb begin
        next_state = state;
        we_raw     = 1'b0;
        MemWData   = 32'h0;
        case (state)
            IDLE:   if (Req) next_state = ACCESS;
            ACCESS: begin
                if (access_err || !req_store) begin
                    next_state = DONE;
                end else if (req_f3 == F3_W) begin
                    we_raw     = 1'b1;
                    MemWData   = req_wdata;
                    next_state = DONE;
                end else begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                we_raw     = 1'b1;
                MemWData   = merge_word;
                next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= IDLE;
            req_store  <= 1'b0;
            req_f3     <= 3'b000;
            req_addr   <= 32'h0;
            req_wdata  <= 32'h0;
            err_flag   <= 1'b0;
            merge_word <= 32'h0;
            load_data  <= 32'h0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (Req) begin
                    req_store <= Store;
                    req_f3    <= Funct3;
                    req_addr  <= ByteAddr;
                    req_wdata <= WData;
                    err_flag  <= 1'b0;
                end
                ACCESS: begin
                    err_flag <= access_err;
                    if (!access_err && !req_store) load_data  <= ext_value;
                    if (!access_err && req_store)  merge_word <= merge_next;
                end
                default: ;
            endcase
        end
    end

    // The RAM writes on the negedge, so a same-cycle Reset must block the strobe.
    assign MemWE     = we_raw & ~Reset;
    assign Ready     = (state == IDLE);
    assign Done      = (state == DONE);
    assign Err       = (state == DONE) && err_flag;
    assign LoadData  = load_data;
    assign MemAddr   = (state == IDLE) ? 32'h0 : {2'b00, req_addr[31:2]};
    assign fsm_state = state;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sub-word load/store front end between the CPU datapath and the 32-word, word-addressed data RAM (negedge write, asynchronous read). It takes one byte-addressed request at a time over a Req/Ready/Done handshake. It performs LB/LBU/LH/LHU/LW with sign/zero extension, and SW directly. SB/SH are done as a read-modify-write over two cycles. Misaligned, illegal and out-of-range accesses are flagged without touching memory.

## Interface
- DEPTH_LOG2, 5, log2 of RAM depth in words; byte addresses ≥ 4<<DEPTH_LOG2 are out of range.
- CLK  in  1  clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high; returns block to IDLE.
- Req  in  1  request valid; sampled only when Ready=1.
- Store  in  1  1 = store, 0 = load.
- Funct3  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
- ByteAddr  in  32  byte address.
- WData  in  32  store data; low byte/half used for SB/SH.
- Ready  out  1  1 only in IDLE.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  valid with Done: misaligned, illegal Funct3 or out-of-range.
- LoadData  out  32  extended load result, held until next load completes.
- MemAddr  out  32  word index to RAM = {2'b00, latched ByteAddr[31:2]}.
- MemWE  out  1  RAM write enable.
- MemWData  out  32  RAM write data.
- MemRData  in  32  RAM asynchronous read data.

## Operation
- FSM states: IDLE, ACCESS, WRITE, DONE.
- IDLE: Ready=1. If Req, latch Store/Funct3/ByteAddr/WData, go to ACCESS. Req in any other state is ignored.
- Error check in ACCESS, from latched fields:
  - misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0
  - illegal: load Funct3 ∈ {011,110,111}; store Funct3 ∉ {000,001,010}
  - out of range: ByteAddr ≥ 4<<DEPTH_LOG2
  - On any error: MemWE=0, set error flag, go to DONE. LoadData is unchanged.
- ACCESS, no error:
  - Load: select byte/half from MemRData by addr[1:0] (little-endian), sign- or zero-extend, register into LoadData, go to DONE.
  - SW: MemWE=1, MemWData=WData, go to DONE.
  - SB/SH: register MemRData into the merge word with the selected byte/half replaced by WData[7:0]/[15:0], go to WRITE.
- WRITE: MemWE=1, MemWData=merge word, go to DONE.
- DONE: Done=1 and Err=flag for one cycle, then go to IDLE.
- MemWE is gated with ~Reset, so no RAM write occurs in a cycle where Reset=1.

## Timing
- Request accepted at edge 0.
- Loads, SW and errored requests: Done high in cycle 2 (after edge 1); Ready returns in cycle 3.
- SB/SH: RAM write at negedge of cycle 2; Done high in cycle 3.
- Back-to-back: a Req held high is re-accepted on the first IDLE cycle, giving a 3-cycle issue interval (4 for SB/SH).
- MemAddr is driven from latched address in all non-IDLE states. In IDLE it is 0.
- Reset values: state IDLE, Ready=1 (combinational from IDLE), Done=0, Err=0, LoadData=0, MemWE=0, MemWData=0, MemAddr=0.
- Reset in any state (including WRITE) aborts the access: no write, no Done, IDLE on the next cycle.

## Structure
- Shared package lsu_pkg:
  - Funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state enum
- One sub-module, lsu_extract: combinational byte/half select plus sign/zero extension from (word, addr[1:0], Funct3). It is reused for the merge mask.

## Test plan
With RAM initialised to word[i] = 0x80000000+i:
- LW 0x0C → Done in cycle 2, LoadData=0x80000003, Err=0, MemWE never high.
- LB 0x0F → LoadData=0xFFFFFF80.
- LBU 0x0F → 0x00000080.
- LHU 0x0E → 0x00008000.
- LH 0x0C → 0x00000003.
- SB 0x0D, WData=0x55 → one MemWE pulse in cycle 2 with MemWData=0x80005503; Done in cycle 3; a following LW 0x0C returns 0x80005503.
- SH 0x0D → Err=1 with Done in cycle 2, no MemWE, RAM unchanged.
- LW 0x80 (DEPTH_LOG2=5) → Err=1, no MemWE, RAM unchanged.
- Funct3=110 load → Err=1; LoadData keeps its previous value.
- SH 0x10, WData=0xBEEF, with Reset asserted in the WRITE cycle → MemWE stays 0, no Done, Ready=1 next cycle, word[4] remains 0x80000004.
